// File: rtl/l1_wb_req_tx.sv
// Writeback-request transmitter: buffers dirty evictions in a small FIFO and
// presents them to the L2 as msg3 WB_REQ beats; clean evictions are only counted.
module l1_wb_req_tx #(
   parameter int          DEPTH       = 4,
   parameter logic [5:0]  SRC_ID      = 6'h00,
   parameter logic [7:0]  WB_REQ_TYPE = 8'h0C,
   parameter int          TAG_W       = 26,
   parameter int          DATA_W      = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              evict_valid,
   output logic              evict_ready,
   input  logic              evict_dirty,
   input  logic [TAG_W-1:0]  evict_tag,
   input  logic [DATA_W-1:0] evict_data,
   output logic              msg3_valid,
   input  logic              msg3_ready,
   output logic [7:0]        msg3_type,
   output logic [5:0]        msg3_source,
   output logic [TAG_W-1:0]  msg3_tag,
   output logic [DATA_W-1:0] msg3_data,
   output logic              wb_pending,
   output logic [7:0]        clean_drop_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_ACTIVE,
      ST_FULL
   } state_e;

   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [7:0]        clean_cnt_q, clean_cnt_d;

   logic [TAG_W-1:0]  tag_mem_q  [DEPTH];
   logic [DATA_W-1:0] data_mem_q [DEPTH];

   state_e            state;
   logic [DEPTH-1:0]  match_vec;
   logic [PTR_W-1:0]  coal_idx;
   logic              coalesce_hit;
   logic              accept;
   logic              do_coal;
   logic              do_enq;
   logic              do_deq;
   logic              do_clean;
   logic              mem_we;
   logic [PTR_W-1:0]  mem_idx;

   always_comb begin
      state = ST_ACTIVE;
      if (count_q == '0)
         state = ST_EMPTY;
      else if (count_q == CNT_W'(DEPTH))
         state = ST_FULL;
   end

   // Only live entries behind the head may absorb a re-eviction; the head is already on the wire.
   always_comb begin
      match_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match_vec[i] = (tag_mem_q[i] == evict_tag)
                     && (CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr_q)) < count_q)
                     && (PTR_W'(i) != rd_ptr_q);
      end
   end

   always_comb begin
      coal_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (match_vec[i])
            coal_idx = PTR_W'(i);
      end
   end

   assign coalesce_hit = evict_dirty & (|match_vec);
   assign evict_ready  = (state != ST_FULL) | ~evict_dirty | coalesce_hit;
   assign accept       = evict_valid & evict_ready;
   assign do_coal      = accept & coalesce_hit;
   assign do_enq       = accept & evict_dirty & ~coalesce_hit;
   assign do_clean     = accept & ~evict_dirty;
   assign do_deq       = msg3_valid & msg3_ready;
   assign mem_we       = do_coal | do_enq;
   assign mem_idx      = do_coal ? coal_idx : wr_ptr_q;

   always_comb begin
      count_d     = count_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      clean_cnt_d = clean_cnt_q;
      if (do_enq)
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_deq)
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_enq, do_deq})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (do_clean && clean_cnt_q != 8'hFF)
         clean_cnt_d = clean_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q     <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         clean_cnt_q <= '0;
      end else begin
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         clean_cnt_q <= clean_cnt_d;
      end
   end

   // A coalesce onto head+1 during a dequeue lands before that entry becomes the head.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         tag_mem_q[mem_idx]  <= evict_tag;
         data_mem_q[mem_idx] <= evict_data;
      end
   end

   assign msg3_valid     = (state != ST_EMPTY);
   assign msg3_type      = msg3_valid ? WB_REQ_TYPE : 8'h00;
   assign msg3_source    = SRC_ID;
   assign msg3_tag       = tag_mem_q[rd_ptr_q];
   assign msg3_data      = data_mem_q[rd_ptr_q];
   assign wb_pending     = msg3_valid;
   assign clean_drop_cnt = clean_cnt_q;

   a_single_match: assert property (@(posedge clk) disable iff (rst)
      (evict_valid && evict_dirty) |-> $onehot0(match_vec));
   a_count_bound: assert property (@(posedge clk) disable iff (rst)
      count_q <= CNT_W'(DEPTH));
   a_no_underflow: assert property (@(posedge clk) disable iff (rst)
      !(do_deq && count_q == '0));

endmodule

// File: tb/tb_l1_wb_req_tx.sv
// Randomized bench for l1_wb_req_tx against a queue-based model of the
// writeback buffer (coalescing, ordering, clean-drop counting).
module tb_l1_wb_req_tx;

   localparam int         DEPTH  = 4;
   localparam int         TAG_W  = 26;
   localparam int         DATA_W = 64;
   localparam logic [5:0] SRC    = 6'h15;
   localparam logic [7:0] WBT    = 8'h0C;

   logic              clk = 1'b0;
   logic              rst;
   logic              evict_valid;
   logic              evict_ready;
   logic              evict_dirty;
   logic [TAG_W-1:0]  evict_tag;
   logic [DATA_W-1:0] evict_data;
   logic              msg3_valid;
   logic              msg3_ready;
   logic [7:0]        msg3_type;
   logic [5:0]        msg3_source;
   logic [TAG_W-1:0]  msg3_tag;
   logic [DATA_W-1:0] msg3_data;
   logic              wb_pending;
   logic [7:0]        clean_drop_cnt;

   l1_wb_req_tx #(
      .DEPTH(DEPTH), .SRC_ID(SRC), .WB_REQ_TYPE(WBT), .TAG_W(TAG_W), .DATA_W(DATA_W)
   ) dut (
      .clk(clk), .rst(rst),
      .evict_valid(evict_valid), .evict_ready(evict_ready), .evict_dirty(evict_dirty),
      .evict_tag(evict_tag), .evict_data(evict_data),
      .msg3_valid(msg3_valid), .msg3_ready(msg3_ready), .msg3_type(msg3_type),
      .msg3_source(msg3_source), .msg3_tag(msg3_tag), .msg3_data(msg3_data),
      .wb_pending(wb_pending), .clean_drop_cnt(clean_drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } ent_t;

   ent_t mq[$];
   int   m_clean;
   int   n_cmp;
   int   n_err;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One cycle: drive at the falling edge, check settled outputs, advance the model
   // to its post-edge state.
   task automatic step(input logic v, input logic d, input logic [TAG_W-1:0] t,
                       input logic [DATA_W-1:0] dt, input logic r, output logic acc);
      int   sz;
      int   hit;
      logic exp_rdy;
      ent_t e;
      @(negedge clk);
      evict_valid = v;
      evict_dirty = d;
      evict_tag   = t;
      evict_data  = dt;
      msg3_ready  = r;
      #1;
      sz  = mq.size();
      hit = -1;
      for (int j = 1; j < sz; j++)
         if (hit < 0 && mq[j].tag == t) hit = j;
      exp_rdy = (sz < DEPTH) || !d || (hit >= 0);
      acc     = v && exp_rdy;
      check("evict_ready", evict_ready, exp_rdy);
      check("msg3_valid", msg3_valid, sz != 0);
      check("msg3_type", msg3_type, (sz != 0) ? WBT : 8'h00);
      check("msg3_source", msg3_source, SRC);
      check("wb_pending", wb_pending, sz != 0);
      check("clean_drop_cnt", clean_drop_cnt, m_clean);
      if (sz != 0) begin
         check("msg3_tag", msg3_tag, mq[0].tag);
         check("msg3_data", msg3_data, mq[0].data);
      end
      if (acc && !d && m_clean < 255) m_clean++;
      if (acc && d && hit >= 0) begin
         e      = mq[hit];
         e.data = dt;
         mq[hit] = e;
      end
      if (sz != 0 && r) void'(mq.pop_front());
      if (acc && d && hit < 0) begin
         e.tag  = t;
         e.data = dt;
         mq.push_back(e);
      end
   endtask

   task automatic check_idle_reset(input string tag);
      check({tag, "_valid"}, msg3_valid, 1'b0);
      check({tag, "_type"}, msg3_type, 8'h00);
      check({tag, "_pending"}, wb_pending, 1'b0);
      check({tag, "_ready"}, evict_ready, 1'b1);
      check({tag, "_clean"}, clean_drop_cnt, 8'd0);
   endtask

   initial begin
      logic acc;
      logic [TAG_W-1:0] nt;
      n_cmp = 0;
      n_err = 0;
      m_clean = 0;
      rst = 1'b1;
      evict_valid = 1'b0;
      evict_dirty = 1'b1;
      evict_tag   = '0;
      evict_data  = '0;
      msg3_ready  = 1'b0;
      #12;
      check_idle_reset("reset");
      @(negedge clk);
      rst = 1'b0;

      // Single dirty eviction, one beat only
      step(1, 1, 26'h1234, 64'hDEAD_BEEF, 1, acc);
      check("t1_accept", acc, 1'b1);
      step(0, 0, 0, 0, 1, acc);
      step(0, 0, 0, 0, 1, acc);
      step(0, 0, 0, 0, 1, acc);

      // Fill to FULL with ready low; fifth dirty eviction must stall
      for (int i = 1; i <= 5; i++) begin
         step(1, 1, TAG_W'(i), 64'(i * 16'h1111), 0, acc);
         check("t2_accept", acc, i <= 4);
      end
      step(0, 0, 0, 0, 1, acc);
      acc = 1'b0;
      for (int k = 0; k < 8 && !acc; k++)
         step(1, 1, 26'd5, 64'h5555, 1, acc);
      check("t2_tag5_accepted", acc, 1'b1);
      for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 1, acc);

      // Coalescing behind the head, and re-eviction of the head tag
      step(1, 1, 26'hA, 64'd1, 0, acc);
      step(1, 1, 26'hB, 64'd2, 0, acc);
      step(1, 1, 26'hB, 64'd3, 0, acc);
      step(0, 0, 0, 0, 0, acc);
      check("t3_count2", mq.size(), 2);
      check("t3_coalesced", mq[1].data, 64'd3);
      step(1, 1, 26'hA, 64'd9, 0, acc);
      check("t3_head_not_coalesced", mq.size(), 3);
      for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 1, acc);

      // Coalesce onto head+1 in the same cycle as the head leaves
      step(1, 1, 26'h20, 64'd20, 0, acc);
      step(1, 1, 26'h21, 64'd21, 0, acc);
      step(1, 1, 26'h21, 64'hCAFE, 1, acc);
      for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1, acc);

      // Clean evictions saturate the drop counter and never produce beats
      for (int k = 0; k < 300; k++) step(1, 0, TAG_W'(k), 64'(k), $urandom_range(0, 1), acc);
      step(0, 0, 0, 0, 0, acc);
      check("t4_clean_sat", clean_drop_cnt, 8'd255);

      // FULL with ready high and a fresh dirty eviction every cycle
      for (int i = 0; i < 4; i++) step(1, 1, TAG_W'(26'h100 + i), 64'(i), 0, acc);
      for (int i = 0; i < 24; i++) begin
         nt = TAG_W'(26'h200 + i);
         step(1, 1, nt, 64'({$urandom, $urandom}), 1, acc);
      end
      for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 1, acc);

      // Asynchronous reset in the middle of a stalled handshake
      step(1, 1, 26'h77, 64'h77, 0, acc);
      step(0, 0, 0, 0, 0, acc);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_idle_reset("t6_midreset");
      mq.delete();
      m_clean = 0;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1, acc);

      // Randomized traffic over a small tag space to exercise coalescing
      for (int k = 0; k < 2500; k++) begin
         step($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0,
              TAG_W'($urandom_range(0, 5)), 64'({$urandom, $urandom}),
              $urandom_range(0, 1), acc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
